// File: rtl/pipe_addsub.sv
// rtl/pipe_addsub.sv - pipelined add/subtract unit with valid/ready stream handshake
module pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic             in_cin,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("pipe_addsub: WIDTH must be a multiple of CHUNK");
  end

  // Global stall: every stage moves together or none does.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Subtract folds into an add of the inverted operand with inverted borrow.
  logic [WIDTH-1:0] b_eff;
  logic             c_first;
  assign b_eff   = in_sub ? ~in_b : in_b;
  assign c_first = in_sub ? !in_cin : in_cin;

  // Stage registers: valid, carry into the next slice, operands and partial sum.
  logic             v_q [STAGES];
  logic             c_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];

  // Stage k reads index k of these; index 0 is the input port, index k+1 is stage k.
  logic             p_v [STAGES+1];
  logic             p_c [STAGES+1];
  logic [WIDTH-1:0] p_a [STAGES+1];
  logic [WIDTH-1:0] p_b [STAGES+1];
  logic [WIDTH-1:0] p_s [STAGES+1];

  logic             n_c [STAGES];
  logic [WIDTH-1:0] n_s [STAGES];

  assign p_v[0] = in_valid;
  assign p_c[0] = c_first;
  assign p_a[0] = in_a;
  assign p_b[0] = b_eff;
  assign p_s[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK:0]   slice;
    logic [WIDTH-1:0] merged;

    assign p_v[k+1] = v_q[k];
    assign p_c[k+1] = c_q[k];
    assign p_a[k+1] = a_q[k];
    assign p_b[k+1] = b_q[k];
    assign p_s[k+1] = s_q[k];

    assign slice = {1'b0, p_a[k][k*CHUNK +: CHUNK]}
                 + {1'b0, p_b[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, p_c[k]};

    // Drop this stage's resolved slice into the partial sum carried along.
    always_comb begin
      merged = p_s[k];
      merged[k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
    end

    assign n_s[k] = merged;
    assign n_c[k] = slice[CHUNK];
  end

  // Shift the whole pipeline (bubbles included) whenever the output can move.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= p_v[k];
        c_q[k] <= n_c[k];
        a_q[k] <= p_a[k];
        b_q[k] <= p_b[k];
        s_q[k] <= n_s[k];
      end
    end
  end

  assign out_valid = v_q[LAST];
  assign out_sum   = s_q[LAST];
  assign out_cout  = c_q[LAST];
  assign out_ovf   = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                     (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
  assign out_zero  = (s_q[LAST] == '0);

endmodule

// File: tb/tb_pipe_addsub.sv
// tb/tb_pipe_addsub.sv - self-checking bench for pipe_addsub
module tb_pipe_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sub, in_cin;
  logic [15:0] in_a, in_b;
  logic        out_valid, out_ready, out_cout, out_ovf, out_zero;
  logic [15:0] out_sum;

  logic        v1_in_valid, v1_in_ready, v1_in_sub, v1_in_cin;
  logic [15:0] v1_in_a, v1_in_b;
  logic        v1_out_valid, v1_out_ready, v1_out_cout, v1_out_ovf, v1_out_zero;
  logic [15:0] v1_out_sum;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pipe_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub), .in_cin(in_cin),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  pipe_addsub #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v1_in_valid), .in_ready(v1_in_ready), .in_sub(v1_in_sub), .in_cin(v1_in_cin),
    .in_a(v1_in_a), .in_b(v1_in_b),
    .out_valid(v1_out_valid), .out_ready(v1_out_ready), .out_sum(v1_out_sum),
    .out_cout(v1_out_cout), .out_ovf(v1_out_ovf), .out_zero(v1_out_zero)
  );

  typedef struct {
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vt[9];

  logic        s_sub [16];
  logic        s_cin [16];
  logic [15:0] s_a   [16];
  logic [15:0] s_b   [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result {cout, ovf, sum} straight from the arithmetic definition.
  function automatic logic [17:0] model(input logic sub, input logic cin,
                                        input logic [15:0] a, input logic [15:0] b);
    logic [15:0] be;
    logic [16:0] full;
    logic        ov;
    be   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, be} + {16'd0, (sub ? !cin : cin)};
    ov   = (a[15] == be[15]) && (full[15] != a[15]);
    return {full[16], ov, full[15:0]};
  endfunction

  initial begin
    logic [17:0] m;
    logic [19:0] held;
    logic        held_on;
    int          sent, got, cyc;

    vt[0] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[1] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
    vt[2] = '{1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vt[4] = '{1'b0, 1'b1, 16'h1234, 16'h4321, 16'h5556, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1'b1, 1'b0, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[6] = '{1'b1, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vt[7] = '{1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1};
    vt[8] = '{1'b0, 1'b1, 16'h0FFF, 16'h0001, 16'h1001, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_cin = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    v1_in_valid = 1'b0; v1_in_sub = 1'b0; v1_in_cin = 1'b0;
    v1_in_a = '0; v1_in_b = '0; v1_out_ready = 1'b1;
    tick(); tick();

    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_sum",   {16'd0, out_sum},   32'd0);
    chk("reset_flags",     {29'd0, out_cout, out_ovf, out_zero}, 32'd1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed table: one beat at a time, latency exactly 4 edges.
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_sub = vt[i].sub; in_cin = vt[i].cin;
      in_a = vt[i].a; in_b = vt[i].b;
      #1;
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      tick(); tick();
      chk($sformatf("vec%0d_early", i), {31'd0, out_valid}, 32'd0);
      tick();
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_sum", i), {16'd0, out_sum}, {16'd0, vt[i].sum});
      chk($sformatf("vec%0d_flags", i), {29'd0, out_cout, out_ovf, out_zero},
          {29'd0, vt[i].cout, vt[i].ovf, vt[i].zero});
    end
    tick();

    // Hand sequence: output stalled holds everything and deasserts in_ready.
    in_valid = 1'b1; in_sub = 1'b0; in_cin = 1'b0; in_a = 16'h0001; in_b = 16'h0002;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    out_ready = 1'b0;
    #1;
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    tick(); tick();
    chk("stall_hold", {15'd0, out_valid, out_sum}, {15'd0, 1'b1, 16'h0003});
    out_ready = 1'b1;
    #1;
    chk("stall_release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("stall_drained", {31'd0, out_valid}, 32'd0);

    // Back-to-back random beats against a random consumer.
    for (int i = 0; i < 16; i++) begin
      s_sub[i] = 1'($urandom_range(0, 1));
      s_cin[i] = 1'($urandom_range(0, 1));
      s_a[i]   = 16'($urandom);
      s_b[i]   = 16'($urandom);
    end
    sent = 0; got = 0; cyc = 0; held_on = 1'b0; held = '0;
    while (got < 16 && cyc < 400) begin
      in_valid = (sent < 16);
      if (sent < 16) begin
        in_sub = s_sub[sent]; in_cin = s_cin[sent]; in_a = s_a[sent]; in_b = s_b[sent];
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (held_on)
        chk("stream_stable", {12'd0, out_valid, out_cout, out_ovf, out_zero, out_sum},
            {12'd0, held});
      if (out_valid && out_ready) begin
        m = model(s_sub[got], s_cin[got], s_a[got], s_b[got]);
        chk($sformatf("stream%0d_result", got),
            {13'd0, out_cout, out_ovf, out_zero, out_sum},
            {13'd0, m[17], m[16], (m[15:0] == 16'd0), m[15:0]});
        got++;
      end
      held_on = out_valid && !out_ready;
      held    = {out_valid, out_cout, out_ovf, out_zero, out_sum};
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("stream_count", got, 16);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("stream_no_extra", {31'd0, out_valid}, 32'd0);

    // Reset with three beats in flight discards them.
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1; in_sub = 1'b0; in_cin = 1'b0;
      in_a = 16'h1111 * 16'(j + 1); in_b = 16'h0101;
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("midreset_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset_sum", {16'd0, out_sum}, 32'd0);
    rst_n = 1'b1;
    in_valid = 1'b1; in_sub = 1'b0; in_cin = 1'b0; in_a = 16'h0F0F; in_b = 16'h00F1;
    #1;
    chk("postreset_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("postreset_early", {31'd0, out_valid}, 32'd0);
    tick();
    chk("postreset_result", {12'd0, out_valid, out_cout, out_ovf, out_zero, out_sum},
        {12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000});

    // Single-stage build: result one cycle after accept.
    v1_in_valid = 1'b1; v1_in_sub = 1'b0; v1_in_cin = 1'b1;
    v1_in_a = 16'h1234; v1_in_b = 16'h4321;
    #1;
    chk("chunk16_before", {31'd0, v1_out_valid}, 32'd0);
    tick();
    v1_in_valid = 1'b0;
    chk("chunk16_result", {12'd0, v1_out_valid, v1_out_cout, v1_out_ovf, v1_out_zero, v1_out_sum},
        {12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h5556});

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
